// File: rtl/dp_issue_ctrl_if.sv
// Request, op-unit and writeback signals of the data-processing issue
// controller. The master side is the decode stage plus op units; the slave
// side is the controller itself.
interface dp_issue_ctrl_if;
  // decode-stage request
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_opcode;
  logic        req_s;
  logic [3:0]  req_rd;
  logic        flush;
  // op unit enables and results
  logic [15:0] op_en;
  logic [31:0] op_rd;
  logic        op_c;
  logic        op_z;
  logic        op_n;
  // architectural flags, also fed back to the op units
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  // register writeback
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal;

  modport master (
    output req_valid, req_opcode, req_s, req_rd, flush,
    output op_rd, op_c, op_z, op_n,
    input  req_ready, op_en, flag_c, flag_z, flag_n,
    input  wb_valid, wb_rd, wb_data, err_illegal
  );

  modport slave (
    input  req_valid, req_opcode, req_s, req_rd, flush,
    input  op_rd, op_c, op_z, op_n,
    output req_ready, op_en, flag_c, flag_z, flag_n,
    output wb_valid, wb_rd, wb_data, err_illegal
  );
endinterface

// File: rtl/dp_issue_ctrl.sv
// Issue controller for ARM data-processing instructions: accepts one decoded
// instruction at a time, pulses the enable of the matching op unit, waits a
// fixed number of cycles, samples the unit's result and flags, then writes
// back the result and/or updates the architectural flags.
module dp_issue_ctrl #(
  parameter logic [15:0] OP_MASK     = 16'hFFFF,
  parameter int          WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          rst,
  dp_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  op_reg;
  logic        s_reg;
  logic [3:0]  rd_reg;
  logic [2:0]  cnt_reg;
  logic        cap_c_reg;
  logic        cap_z_reg;
  logic        cap_n_reg;
  logic [3:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic        flag_c_reg;
  logic        flag_z_reg;
  logic        flag_n_reg;
  logic        err_reg;
  logic        ready_en_reg;

  logic        req_ready_int;
  logic        handshake;
  logic        req_legal;
  logic        op_is_cmp;
  logic        capture;

  // TST/TEQ/CMP/CMN (8..B) only set flags and never write a register
  assign op_is_cmp     = (op_reg[3:2] == 2'b10);
  assign req_legal     = OP_MASK[bus.req_opcode];
  // ready stays low until the first edge after reset release
  assign req_ready_int = (state_reg == ST_IDLE) && ready_en_reg;
  assign handshake     = bus.req_valid && req_ready_int;
  // result sampling point: last WAIT cycle, unless the instruction is flushed
  assign capture       = (state_reg == ST_WAIT) && !bus.flush && (cnt_reg <= 3'd1);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state logic; flush only aborts while the op is in flight
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (handshake && req_legal) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = bus.flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_next = ST_IDLE;
        end else if (cnt_reg <= 3'd1) begin
          state_next = ST_WB;
        end
      end
      ST_WB: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // request latch, wait counter and illegal-opcode pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg       <= 4'd0;
      s_reg        <= 1'b0;
      rd_reg       <= 4'd0;
      cnt_reg      <= 3'd0;
      err_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      err_reg      <= handshake && !req_legal;
      if (handshake) begin
        op_reg <= bus.req_opcode;
        s_reg  <= bus.req_s;
        rd_reg <= bus.req_rd;
      end
      if (state_reg == ST_ISSUE) begin
        cnt_reg <= bus.flush ? 3'd0 : WAIT_LOAD;
      end else if (state_reg == ST_WAIT) begin
        cnt_reg <= (bus.flush || cnt_reg == 3'd0) ? 3'd0 : cnt_reg - 3'd1;
      end
    end
  end

  // result capture; wb_rd/wb_data only move when a writeback is about to show
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_c_reg   <= 1'b0;
      cap_z_reg   <= 1'b0;
      cap_n_reg   <= 1'b0;
      wb_rd_reg   <= 4'd0;
      wb_data_reg <= 32'd0;
    end else if (capture) begin
      cap_c_reg <= bus.op_c;
      cap_z_reg <= bus.op_z;
      cap_n_reg <= bus.op_n;
      if (!op_is_cmp) begin
        wb_rd_reg   <= rd_reg;
        wb_data_reg <= bus.op_rd;
      end
    end
  end

  // architectural flags commit on the WB exit edge; flush is ignored in WB
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
    end else if ((state_reg == ST_WB) && (s_reg || op_is_cmp)) begin
      flag_c_reg <= cap_c_reg;
      flag_z_reg <= cap_z_reg;
      flag_n_reg <= cap_n_reg;
    end
  end

  // outputs: op_en and wb_valid decode straight from state so reset clears them at once
  assign bus.req_ready   = req_ready_int;
  assign bus.op_en       = (state_reg == ST_ISSUE) ? (16'h0001 << op_reg) : 16'h0000;
  assign bus.wb_valid    = (state_reg == ST_WB) && !op_is_cmp;
  assign bus.wb_rd       = wb_rd_reg;
  assign bus.wb_data     = wb_data_reg;
  assign bus.err_illegal = err_reg;
  assign bus.flag_c      = flag_c_reg;
  assign bus.flag_z      = flag_z_reg;
  assign bus.flag_n      = flag_n_reg;

endmodule

// File: tb/tb_dp_issue_ctrl.sv
// Directed bench for dp_issue_ctrl: the driver pushes expected op_en pulses,
// writebacks and illegal-opcode pulses into queues; a negedge monitor pops
// and compares them, including the cycle at which each event appears.
module tb_dp_issue_ctrl;
  localparam int          W    = 3;
  localparam logic [15:0] MASK = 16'h7FFF;

  localparam int M_NORM    = 0;
  localparam int M_FL_WAIT = 1;
  localparam int M_FL_IDLE = 2;
  localparam int M_FL_WB   = 3;
  localparam int M_RST_WB  = 4;

  typedef struct {
    logic [31:0] val;
    logic [3:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  exp_t q_issue[$];
  exp_t q_wb[$];
  exp_t q_err[$];
  exp_t mon_e;

  logic        fc = 1'b0, fz = 1'b0, fn = 1'b0;
  logic [3:0]  last_rd = 4'd0;
  logic [31:0] last_data = 32'd0;

  dp_issue_ctrl_if bus ();

  dp_issue_ctrl #(.OP_MASK(MASK), .WAIT_CYCLES(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // monitor: every DUT output event must match the head of its queue
  always @(negedge clk) begin
    if (bus.op_en !== 16'h0000) begin
      if (q_issue.size() == 0) begin
        check("op_en_unexpected", 32'(bus.op_en), 32'd0);
      end else begin
        mon_e = q_issue.pop_front();
        check("op_en", 32'(bus.op_en), mon_e.val);
        check("op_en_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (bus.wb_valid === 1'b1) begin
      if (q_wb.size() == 0) begin
        check("wb_unexpected", 32'(bus.wb_valid), 32'd0);
      end else begin
        mon_e = q_wb.pop_front();
        check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        check("wb_data", bus.wb_data, mon_e.val);
        check("wb_cycle", 32'(cyc), 32'(mon_e.cyc));
        $display("[TB] cyc %0d wb rd=%0d data=0x%h", cyc, bus.wb_rd, bus.wb_data);
      end
    end
    if (bus.err_illegal === 1'b1) begin
      if (q_err.size() == 0) begin
        check("err_unexpected", 32'(bus.err_illegal), 32'd0);
      end else begin
        mon_e = q_err.pop_front();
        check("err_cycle", 32'(cyc), 32'(mon_e.cyc));
        $display("[TB] cyc %0d err_illegal", cyc);
      end
    end
  end

  task automatic do_req(input logic [3:0] op, input logic s, input logic [3:0] rd,
                        input logic [31:0] data, input logic c, input logic z,
                        input logic n, input int mode);
    int   h;
    int   t;
    int   exp_ready;
    logic legal;
    logic cmp;
    exp_t e;
    legal = MASK[op];
    cmp   = (op[3:2] == 2'b10);
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.req_ready !== 1'b1) begin
      check("ready_timeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_s      = s;
    bus.req_rd     = rd;
    bus.op_rd      = data;
    bus.op_c       = c;
    bus.op_z       = z;
    bus.op_n       = n;
    bus.flush      = (mode == M_FL_IDLE);
    h = cyc + 1;
    if (legal) begin
      e.val = 32'(16'h0001 << op); e.rd = 4'd0; e.cyc = h;
      q_issue.push_back(e);
      if (!cmp && mode != M_FL_WAIT && mode != M_RST_WB) begin
        e.val = data; e.rd = rd; e.cyc = h + 1 + W;
        q_wb.push_back(e);
      end
    end else begin
      e.val = 32'd0; e.rd = 4'd0; e.cyc = h;
      q_err.push_back(e);
    end
    @(negedge clk);
    // scramble request fields to prove the controller latched them
    bus.req_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.req_opcode = ~op;
    bus.req_rd     = ~rd;
    bus.req_s      = ~s;
    exp_ready = legal ? h + 2 + W : h;
    if (mode == M_FL_WAIT) begin
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      exp_ready = h + 2;
    end else if (mode == M_FL_WB) begin
      while (cyc < h + 1 + W) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
    end else if (mode == M_RST_WB) begin
      while (cyc < h + W) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      check("rst_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 32'd0);
      check("rst_wb_data", bus.wb_data, 32'd0);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      fc = 1'b0; fz = 1'b0; fn = 1'b0;
      last_rd = 4'd0; last_data = 32'd0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);
      $display("[TB] cyc %0d op=%h reset during WB", cyc, op);
      return;
    end
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_cycle", 32'(cyc), 32'(exp_ready));
    if (legal && mode != M_FL_WAIT) begin
      if (s || cmp) begin
        fc = c; fz = z; fn = n;
      end
      if (!cmp) begin
        last_rd = rd; last_data = data;
      end
    end
    check("flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 32'({fc, fz, fn}));
    check("wb_rd_hold", 32'(bus.wb_rd), 32'(last_rd));
    check("wb_data_hold", bus.wb_data, last_data);
    $display("[TB] cyc %0d op=%h s=%0d rd=%0d mode=%0d flags czn=%b%b%b",
             cyc, op, s, rd, mode, bus.flag_c, bus.flag_z, bus.flag_n);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_opcode = 4'd0;
    bus.req_s      = 1'b0;
    bus.req_rd     = 4'd0;
    bus.flush      = 1'b0;
    bus.op_rd      = 32'd0;
    bus.op_c       = 1'b0;
    bus.op_z       = 1'b0;
    bus.op_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_op_en", 32'(bus.op_en), 32'd0);
    check("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("reset_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("reset_wb_data", bus.wb_data, 32'd0);
    check("reset_err", 32'(bus.err_illegal), 32'd0);
    check("reset_flags", 32'({bus.flag_c, bus.flag_z, bus.flag_n}), 32'd0);
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(bus.req_ready), 32'd1);

    do_req(4'h4, 1'b1, 4'd3,  32'h0000_0000, 1'b0, 1'b1, 1'b0, M_NORM);    // ADD S
    do_req(4'hA, 1'b0, 4'd5,  32'h0000_1234, 1'b0, 1'b0, 1'b1, M_NORM);    // CMP
    do_req(4'hF, 1'b1, 4'd6,  32'h1111_1111, 1'b1, 1'b1, 1'b1, M_NORM);    // MVN absent
    do_req(4'h0, 1'b1, 4'd4,  32'h5555_5555, 1'b1, 1'b1, 1'b0, M_FL_WAIT); // AND flushed
    do_req(4'h2, 1'b0, 4'd7,  32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, M_NORM);    // SUB no S
    do_req(4'h8, 1'b1, 4'd9,  32'h0000_0005, 1'b1, 1'b0, 1'b0, M_NORM);    // TST
    do_req(4'h1, 1'b1, 4'd9,  32'h0000_A5A5, 1'b0, 1'b0, 1'b1, M_FL_IDLE); // EOR, flush in IDLE
    do_req(4'hD, 1'b1, 4'd15, 32'h8000_0000, 1'b1, 1'b0, 1'b1, M_FL_WB);   // MOV, flush in WB
    do_req(4'hC, 1'b1, 4'd2,  32'h0000_FFFF, 1'b1, 1'b1, 1'b1, M_RST_WB);  // ORR, reset in WB
    do_req(4'h5, 1'b1, 4'd1,  32'h0000_0042, 1'b0, 1'b0, 1'b0, M_NORM);    // ADC after reset
    do_req(4'h3, 1'b1, 4'd8,  32'h7000_0001, 1'b1, 1'b1, 1'b0, M_NORM);    // RSB back-to-back
    do_req(4'hB, 1'b0, 4'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b1, M_NORM);    // CMN

    repeat (6) @(negedge clk);
    check("issue_queue_empty", 32'(q_issue.size()), 32'd0);
    check("wb_queue_empty", 32'(q_wb.size()), 32'd0);
    check("err_queue_empty", 32'(q_err.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
